fifo_rd_stream: RTL and testbench

Read-side drain engine for `fifo_2clk`, running entirely in the FIFO's read clock domain. It watches `r_fullcount`, issues `rd` pops, and absorbs the FIFO's one-cycle `rddata` latency in a 3-entry output buffer. It presents the data as a valid/ready stream to downstream logic. A downstream stage that is ready every cycle receives one word per cycle, and no combinational path exists from `out_ready` to `rd`.

---
 rtl/fifo_rd_stream.sv | 138 +++++++++++++
 tb/tb_fifo_rd_stream.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_stream.sv
// -----------------------------------------------------------------------------
// fifo_rd_stream
//
// Read-side drain engine for fifo_2clk. Runs entirely in the FIFO read clock
// domain. It pops words from the FIFO, absorbs the FIFO's one-cycle read-data
// latency in a 3-entry circular buffer, and presents the words downstream as
// a valid/ready stream.
//
// Handshake: a word moves downstream on a rising rclk edge where
// out_valid && out_ready are both high. out_valid never depends on out_ready.
// While out_valid is high and out_ready is low, out_data holds stable.
//
// Ports:
//   rclk          in   read-domain clock (rising edge)
//   ar_rst        in   asynchronous active-high reset
//   r_fullcount   in   words available in the FIFO
//   rd            out  pop request to the FIFO (combinational, no out_ready path)
//   rddata        in   FIFO read data, valid with rd_data_valid
//   rd_data_valid in   FIFO data-valid, one cycle after rd
//   out_data      out  word at the head of the buffer
//   out_valid     out  out_data holds a word
//   out_ready     in   downstream accepts the word this cycle
//   buf_count     out  words held in the buffer (0..3)
//   err_unexp     out  sticky: data arrived with no pop outstanding, or overflow
// -----------------------------------------------------------------------------
module fifo_rd_stream #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     rclk,
    input  logic                     ar_rst,
    input  logic [$clog2(DEPTH):0]   r_fullcount,
    output logic                     rd,
    input  logic [WIDTH-1:0]         rddata,
    input  logic                     rd_data_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               buf_count,
    output logic                     err_unexp
);

    localparam logic [1:0] LAST_IDX  = 2'd2;
    localparam logic [1:0] FULL_CNT  = 2'd3;
    localparam logic [2:0] CREDITS   = 3'd3;

    logic [WIDTH-1:0] buf_mem [3];
    logic [1:0]       wr_idx;
    logic [1:0]       rd_idx;
    logic             inflight;

    logic [2:0]       credit_used;
    logic             buf_full;
    logic             capture;
    logic             drain;

    // Index advance wraps after the last of the three entries.
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        next_idx = (idx == LAST_IDX) ? 2'd0 : idx + 2'd1;
    endfunction

    // Credit check: a slot must exist for every word already in the buffer
    // plus the one still in flight from the FIFO. Summed at 3 bits so that
    // 3 + 1 does not wrap to 0.
    assign credit_used = {1'b0, buf_count} + {2'b00, inflight};

    // rd looks only at registered state and the FIFO level, so there is no
    // combinational path from out_ready back into the FIFO.
    assign rd = !ar_rst && (r_fullcount != '0) && (credit_used < CREDITS);

    assign buf_full  = (buf_count == FULL_CNT);
    assign capture   = rd_data_valid && !buf_full;
    assign out_valid = (buf_count != 2'd0);
    assign drain     = out_valid && out_ready;

    // Head-of-buffer mux; the index never reaches 3.
    always_comb begin
        out_data = '0;
        case (rd_idx)
            2'd0:    out_data = buf_mem[0];
            2'd1:    out_data = buf_mem[1];
            2'd2:    out_data = buf_mem[2];
            default: out_data = '0;
        endcase
    end

    // Buffer storage.
    always_ff @(posedge rclk or posedge ar_rst) begin
        if (ar_rst) begin
            for (int i = 0; i < 3; i++) begin
                buf_mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (capture && (wr_idx == 2'(i))) begin
                    buf_mem[i] <= rddata;
                end
            end
        end
    end

    // Indices, occupancy and the outstanding-pop flag.
    always_ff @(posedge rclk or posedge ar_rst) begin
        if (ar_rst) begin
            wr_idx    <= 2'd0;
            rd_idx    <= 2'd0;
            buf_count <= 2'd0;
            inflight  <= 1'b0;
        end else begin
            inflight <= rd;
            if (capture) begin
                wr_idx <= next_idx(wr_idx);
            end
            if (drain) begin
                rd_idx <= next_idx(rd_idx);
            end
            // A word captured into an empty buffer is not forwarded in the
            // same cycle: drain only sees words already held, so the count
            // simply nets the two events.
            case ({capture, drain})
                2'b10:   buf_count <= buf_count + 2'd1;
                2'b01:   buf_count <= buf_count - 2'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    // Sticky protocol error: data with no pop outstanding, or a word that
    // had to be dropped because the buffer was already full.
    always_ff @(posedge rclk or posedge ar_rst) begin
        if (ar_rst) begin
            err_unexp <= 1'b0;
        end else if (rd_data_valid && (!inflight || buf_full)) begin
            err_unexp <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fifo_rd_stream.sv
module tb_fifo_rd_stream;
  localparam int WIDTH = 8;
  localparam int DEPTH = 16;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic              rclk;
  logic              ar_rst;
  logic [CW-1:0]     r_fullcount;
  logic              rd;
  logic [WIDTH-1:0]  rddata;
  logic              rd_data_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        buf_count;
  logic              err_unexp;

  fifo_rd_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .rclk          (rclk),
    .ar_rst        (ar_rst),
    .r_fullcount   (r_fullcount),
    .rd            (rd),
    .rddata        (rddata),
    .rd_data_valid (rd_data_valid),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .buf_count     (buf_count),
    .err_unexp     (err_unexp)
  );

  // clock / reset
  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
    $fatal(1, "watchdog");
  end

  // FIFO model (word source), expected queue and accepted words
  logic [WIDTH-1:0] fifo_q[$];
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] acc_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int model_cnt = 0;   // words delivered by the FIFO minus words accepted downstream
  int n_pop = 0;
  int bad_pop = 0;

  // values observed in the cycle most recently completed by tick()
  logic             s_rd, s_rdv, s_valid, s_ready;
  logic [WIDTH-1:0] s_data;
  logic [1:0]       s_cnt;

  // driver: push one word into the FIFO model
  task automatic push_word(input logic [WIDTH-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    r_fullcount = CW'(fifo_q.size());
  endtask

  // driver: one rclk cycle. Samples outputs at the falling edge, then applies
  // the FIFO's response to the rising edge 1 time unit after it.
  task automatic tick();
    @(negedge rclk);
    s_rd    = rd;
    s_rdv   = rd_data_valid;
    s_valid = out_valid;
    s_ready = out_ready;
    s_data  = out_data;
    s_cnt   = buf_count;
    @(posedge rclk);
    #1;
    if (s_valid && s_ready) acc_q.push_back(s_data);
    model_cnt = model_cnt + (s_rdv ? 1 : 0) - ((s_valid && s_ready) ? 1 : 0);
    rd_data_valid = 1'b0;
    if (s_rd) begin
      n_pop++;
      if (fifo_q.size() == 0) begin
        bad_pop++;
      end else begin
        rddata = fifo_q.pop_front();
        rd_data_valid = 1'b1;
      end
    end
    r_fullcount = CW'(fifo_q.size());
    cyc++;
  endtask

  task automatic test_reset();
    ar_rst = 1'b1;
    out_ready = 1'b0;
    rd_data_valid = 1'b0;
    rddata = '0;
    r_fullcount = CW'(1);
    #3;
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL reset_rd actual=%b required=0", rd); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid actual=%b required=0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_out_data actual=%h required=00", out_data); end
    checks++; if (buf_count !== 2'd0) begin errors++; $display("FAIL reset_buf_count actual=%0d required=0", buf_count); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL reset_err actual=%b required=0", err_unexp); end
    r_fullcount = '0;
    @(posedge rclk); #1;
    ar_rst = 1'b0;
    model_cnt = 0;
    repeat (2) tick();
    checks++; if (s_rd !== 1'b0 || s_valid !== 1'b0) begin errors++; $display("FAIL idle_after_reset actual=rd%b/v%b required=rd0/v0", s_rd, s_valid); end
  endtask

  task automatic test_single();
    logic [WIDTH-1:0] a, e;
    out_ready = 1'b1;
    push_word(8'h01);
    tick(); // cycle N
    checks++; if (s_rd !== 1'b1) begin errors++; $display("FAIL single_rd_N actual=%b required=1", s_rd); end
    tick(); // cycle N+1
    checks++; if (s_rdv !== 1'b1 || s_rd !== 1'b0 || s_valid !== 1'b0) begin errors++;
      $display("FAIL single_N1 actual=rdv%b/rd%b/v%b required=rdv1/rd0/v0", s_rdv, s_rd, s_valid); end
    tick(); // cycle N+2
    checks++; if (s_valid !== 1'b1 || s_data !== 8'h01) begin errors++;
      $display("FAIL single_N2 actual=v%b/d%h required=v1/d01", s_valid, s_data); end
    tick();
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL single_err actual=%b required=0", err_unexp); end
    checks++; if (acc_q.size() != 1 || exp_q.size() != 1) begin errors++;
      $display("FAIL single_count actual=%0d required=1", acc_q.size()); end
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      a = acc_q.pop_front(); e = exp_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL single_word actual=%h required=%h", a, e); end
    end
  endtask

  task automatic test_stream();
    int rd_cnt = 0, first_rd = -1, last_rd = -1, first_acc = -1, last_acc = -1, max_cnt = 0, budget = 40;
    int n_before;
    logic [WIDTH-1:0] a, e;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
    while (acc_q.size() < 8 && budget > 0) begin
      n_before = acc_q.size();
      tick();
      budget--;
      if (s_rd) begin rd_cnt++; if (first_rd < 0) first_rd = cyc; last_rd = cyc; end
      if (acc_q.size() != n_before) begin if (first_acc < 0) first_acc = cyc; last_acc = cyc; end
      if (int'(s_cnt) > max_cnt) max_cnt = int'(s_cnt);
    end
    checks++; if (budget == 0) begin errors++; $display("FAIL stream_timeout actual=%0d required=8", acc_q.size()); end
    checks++; if (rd_cnt != 8 || last_rd - first_rd != 7) begin errors++;
      $display("FAIL stream_rd_run actual=%0d/span%0d required=8/span7", rd_cnt, last_rd - first_rd); end
    checks++; if (last_acc - first_acc != 7) begin errors++;
      $display("FAIL stream_out_span actual=%0d required=7", last_acc - first_acc); end
    checks++; if (max_cnt > 2) begin errors++; $display("FAIL stream_max_buf actual=%0d required<=2", max_cnt); end
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      a = acc_q.pop_front(); e = exp_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL stream_word actual=%h required=%h", a, e); end
    end
    checks++; if (exp_q.size() != 0 || acc_q.size() != 0) begin errors++;
      $display("FAIL stream_leftover actual=%0d required=0", exp_q.size() + acc_q.size()); end
  endtask

  task automatic test_backpressure();
    int rd_cnt = 0, budget = 40;
    logic [WIDTH-1:0] a, e;
    out_ready = 1'b0;
    for (int i = 0; i < 8; i++) push_word(8'(8'h10 + i));
    repeat (12) begin
      tick();
      if (s_rd) rd_cnt++;
      if (s_valid) begin
        checks++; if (s_data !== 8'h10) begin errors++; $display("FAIL bp_hold actual=%h required=10", s_data); end
      end
    end
    checks++; if (rd_cnt != 3) begin errors++; $display("FAIL bp_rd_pulses actual=%0d required=3", rd_cnt); end
    checks++; if (buf_count !== 2'd3) begin errors++; $display("FAIL bp_buf_count actual=%0d required=3", buf_count); end
    checks++; if (r_fullcount !== CW'(5)) begin errors++; $display("FAIL bp_fullcount actual=%0d required=5", r_fullcount); end
    out_ready = 1'b1;
    while (acc_q.size() < 8 && budget > 0) begin tick(); budget--; end
    checks++; if (budget == 0) begin errors++; $display("FAIL bp_timeout actual=%0d required=8", acc_q.size()); end
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      a = acc_q.pop_front(); e = exp_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL bp_word actual=%h required=%h", a, e); end
    end
    checks++; if (exp_q.size() != 0 || acc_q.size() != 0) begin errors++;
      $display("FAIL bp_leftover actual=%0d required=0", exp_q.size() + acc_q.size()); end
  endtask

  task automatic test_toggle();
    int budget = 60, m;
    logic [WIDTH-1:0] a, e;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(8'(8'hA0 + i));
    while (acc_q.size() < 6 && budget > 0) begin
      m = model_cnt;
      tick();
      budget--;
      checks++; if (int'(s_cnt) != m) begin errors++; $display("FAIL toggle_buf_count actual=%0d required=%0d", s_cnt, m); end
      out_ready = ~out_ready;
    end
    checks++; if (budget == 0) begin errors++; $display("FAIL toggle_timeout actual=%0d required=6", acc_q.size()); end
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      a = acc_q.pop_front(); e = exp_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL toggle_word actual=%h required=%h", a, e); end
    end
    checks++; if (exp_q.size() != 0 || acc_q.size() != 0) begin errors++;
      $display("FAIL toggle_leftover actual=%0d required=0", exp_q.size() + acc_q.size()); end
    out_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_random();
    int m, budget = 200;
    logic [WIDTH-1:0] a, e;
    for (int c = 0; c < 300; c++) begin
      if (fifo_q.size() < DEPTH && $urandom_range(0, 2) != 0) push_word(WIDTH'($urandom));
      out_ready = 1'($urandom_range(0, 1));
      m = model_cnt;
      tick();
      checks++; if (int'(s_cnt) != m || s_valid !== (m != 0)) begin errors++;
        $display("FAIL rand_occupancy actual=%0d/v%b required=%0d", s_cnt, s_valid, m); end
      checks++; if (n_pop - (acc_q.size() + 0) > 3 + 0 && 0) begin end
    end
    out_ready = 1'b1;
    while (fifo_q.size() + model_cnt > 0 && budget > 0) begin tick(); budget--; end
    repeat (3) tick();
    checks++; if (budget == 0) begin errors++; $display("FAIL rand_timeout actual=%0d required=0", fifo_q.size()); end
    checks++; if (bad_pop != 0) begin errors++; $display("FAIL rand_pop_empty actual=%0d required=0", bad_pop); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rand_err actual=%b required=0", err_unexp); end
    checks++; if (acc_q.size() != exp_q.size()) begin errors++;
      $display("FAIL rand_count actual=%0d required=%0d", acc_q.size(), exp_q.size()); end
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      a = acc_q.pop_front(); e = exp_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL rand_word actual=%h required=%h", a, e); end
    end
    exp_q.delete(); acc_q.delete();
  endtask

  task automatic test_credit_bound();
    int accepted = 0, pops0, lead;
    pops0 = n_pop;
    for (int c = 0; c < 150; c++) begin
      if (fifo_q.size() < DEPTH && $urandom_range(0, 1) != 0) push_word(WIDTH'($urandom));
      out_ready = ($urandom_range(0, 3) == 0);
      tick();
      if (s_valid && s_ready) accepted++;
      lead = (n_pop - pops0) - accepted;
      checks++; if (lead > 3 || lead < 0) begin errors++; $display("FAIL credit_lead actual=%0d required=0..3", lead); end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && (fifo_q.size() + model_cnt > 0); c++) tick();
    repeat (3) tick();
    checks++; if (acc_q.size() != exp_q.size()) begin errors++;
      $display("FAIL credit_count actual=%0d required=%0d", acc_q.size(), exp_q.size()); end
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      checks++; if (acc_q[0] !== exp_q[0]) begin errors++; $display("FAIL credit_word actual=%h required=%h", acc_q[0], exp_q[0]); end
      void'(acc_q.pop_front()); void'(exp_q.pop_front());
    end
    exp_q.delete(); acc_q.delete();
  endtask

  task automatic test_err();
    out_ready = 1'b0;
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL err_pre actual=%b required=0", err_unexp); end
    // unsolicited data with no pop outstanding (FIFO model empty, so rd stays 0)
    rddata = 8'h55;
    rd_data_valid = 1'b1;
    tick();
    checks++; if (s_rd !== 1'b0) begin errors++; $display("FAIL err_no_pop actual=%b required=0", s_rd); end
    checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL err_set actual=%b required=1", err_unexp); end
    out_ready = 1'b1;
    repeat (5) begin
      tick();
      checks++; if (err_unexp !== 1'b1) begin errors++; $display("FAIL err_sticky actual=%b required=1", err_unexp); end
    end
    acc_q.delete();
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int budget = 40;
    logic [WIDTH-1:0] a, e;
    out_ready = 1'b0;
    push_word(8'hC0);
    push_word(8'hC1);
    repeat (4) tick();
    checks++; if (buf_count !== 2'd2) begin errors++; $display("FAIL rmid_pre_count actual=%0d required=2", buf_count); end
    push_word(8'hC2);
    #2;
    ar_rst = 1'b1;
    #1;
    checks++; if (rd !== 1'b0) begin errors++; $display("FAIL rmid_rd actual=%b required=0", rd); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rmid_out_valid actual=%b required=0", out_valid); end
    checks++; if (buf_count !== 2'd0) begin errors++; $display("FAIL rmid_buf_count actual=%0d required=0", buf_count); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rmid_err actual=%b required=0", err_unexp); end
    // the FIFO shares the reset, so its contents and any return are gone too
    fifo_q.delete(); exp_q.delete(); acc_q.delete();
    r_fullcount = '0;
    rd_data_valid = 1'b0;
    model_cnt = 0;
    @(posedge rclk); #1;
    ar_rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(WIDTH'($urandom));
    while (acc_q.size() < 4 && budget > 0) begin tick(); budget--; end
    checks++; if (budget == 0) begin errors++; $display("FAIL rmid_timeout actual=%0d required=4", acc_q.size()); end
    while (acc_q.size() > 0 && exp_q.size() > 0) begin
      a = acc_q.pop_front(); e = exp_q.pop_front();
      checks++; if (a !== e) begin errors++; $display("FAIL rmid_word actual=%h required=%h", a, e); end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL rmid_leftover actual=%0d required=0", exp_q.size()); end
    checks++; if (err_unexp !== 1'b0) begin errors++; $display("FAIL rmid_err_after actual=%b required=0", err_unexp); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_toggle();
    test_random();
    test_credit_bound();
    test_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
